// File: rtl/tp_in_monitor.sv
// -----------------------------------------------------------------------------
// tp_in_monitor
//
// Watches the test-point pins that are configured as inputs, synchronizes them
// into the CLK domain, detects rising edges on enabled channels and logs each
// edge event as {timestamp, edge vector} into a small FIFO that firmware or a
// bench reads back.
//
// Ports:
//   CLK      in   system clock
//   RST_B    in   asynchronous active-low reset
//   TP_IN    in   raw test-point inputs (asynchronous to CLK)
//   CH_MASK  in   1 = channel enabled for edge capture
//   ARM      in   pulse: start a capture (accepted only from IDLE)
//   STOP     in   pulse: end the capture
//   CLR      in   pulse: flush FIFO, clear flags, counters and timestamp
//   RD_EN    in   FIFO read request
//   RD_DATA  out  {timestamp, edge vector} of the last popped entry
//   RD_VALID out  RD_DATA updated this cycle
//   EMPTY    out  FIFO empty
//   FULL     out  FIFO holds 2^DEPTH_LOG2 entries
//   OVFL     out  sticky: an event was lost
//   STATE    out  00 IDLE, 01 ARMED, 10 FULL
//   EVT_CNT  out  accepted events, saturating
//   LEVEL    out  synchronized pin levels
//
// Read handshake: a pop happens in any cycle where RD_EN=1 and EMPTY=0; the
// popped entry appears on RD_DATA the next cycle together with a one-cycle
// RD_VALID pulse. RD_EN while EMPTY=1 is ignored and RD_DATA holds.
// -----------------------------------------------------------------------------
module tp_in_monitor #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TS_W        = 16,
    parameter int DEPTH_LOG2  = 4
) (
    input  logic                    CLK,
    input  logic                    RST_B,
    input  logic [WIDTH-1:0]        TP_IN,
    input  logic [WIDTH-1:0]        CH_MASK,
    input  logic                    ARM,
    input  logic                    STOP,
    input  logic                    CLR,
    input  logic                    RD_EN,
    output logic [TS_W+WIDTH-1:0]   RD_DATA,
    output logic                    RD_VALID,
    output logic                    EMPTY,
    output logic                    FULL,
    output logic                    OVFL,
    output logic [1:0]              STATE,
    output logic [15:0]             EVT_CNT,
    output logic [WIDTH-1:0]        LEVEL
);

    localparam int                  DEPTH    = 2 ** DEPTH_LOG2;
    localparam int                  CW       = DEPTH_LOG2 + 1;
    localparam int                  ENTRY_W  = TS_W + WIDTH;
    localparam logic [CW-1:0]       FULL_CNT = DEPTH[CW-1:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_FULL  = 2'b10
    } state_t;

    // -------------------------------------------------------------------------
    // Synchronizer chain and previous-level register
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= TP_IN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // -------------------------------------------------------------------------
    // Capture state, FIFO control and read port
    // -------------------------------------------------------------------------
    state_t                 r_state;
    logic [TS_W-1:0]        r_ts;
    logic [DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic                   r_ovfl;
    logic [15:0]            r_evt_cnt;
    logic [ENTRY_W-1:0]     r_rd_data;
    logic                   r_rd_valid;
    logic [ENTRY_W-1:0]     r_mem [DEPTH];

    logic [WIDTH-1:0]       w_edge;
    logic                   w_evt;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_rd;
    logic                   w_wr_try;
    logic                   w_wr;
    logic                   w_drop;
    logic                   w_arm_ok;
    logic [CW-1:0]          w_count_nxt;

    always_comb begin
        // Mask is applied combinationally so a mask change acts in the same
        // cycle; prev tracks the unmasked level, so unmasking a channel that
        // is already high cannot fake an edge.
        w_edge   = r_sync[SYNC_STAGES-1] & ~r_prev & CH_MASK;
        w_evt    = |w_edge;
        w_empty  = (r_count == '0);
        w_full   = (r_count == FULL_CNT);
        // CLR discards any same-cycle read or write.
        w_rd     = RD_EN & ~w_empty & ~CLR;
        w_wr_try = (r_state == S_ARMED) & w_evt & ~CLR;
        // The full check uses the occupancy before any same-cycle pop, so a
        // read never rescues a write into a full FIFO.
        w_wr     = w_wr_try & ~w_full;
        w_drop   = w_wr_try & w_full;
        // STOP outranks ARM.
        w_arm_ok = (r_state == S_IDLE) & ARM & ~STOP & ~CLR;
        w_count_nxt = r_count + CW'(w_wr) - CW'(w_rd);
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            r_state    <= S_IDLE;
            r_ts       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovfl     <= 1'b0;
            r_evt_cnt  <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (CLR) begin
            r_state    <= S_IDLE;
            r_ts       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovfl     <= 1'b0;
            r_evt_cnt  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_ts       <= w_arm_ok ? '0 : r_ts + TS_W'(1);
            r_rd_valid <= w_rd;
            r_count    <= w_count_nxt;

            if (w_rd) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + DEPTH_LOG2'(1);
            end

            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
                if (r_evt_cnt != 16'hFFFF) begin
                    r_evt_cnt <= r_evt_cnt + 16'd1;
                end
            end

            if (w_drop || ((r_state == S_FULL) && w_evt)) begin
                r_ovfl <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_arm_ok) begin
                        r_state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    // One-shot: the write that fills the FIFO ends the capture.
                    if (STOP) begin
                        r_state <= S_IDLE;
                    end else if (w_wr && (w_count_nxt == FULL_CNT)) begin
                        r_state <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (STOP) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Storage array carries no reset; entries are only visible through the
    // pointers, which do reset.
    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {r_ts, w_edge};
        end
    end

    assign RD_DATA  = r_rd_data;
    assign RD_VALID = r_rd_valid;
    assign EMPTY    = w_empty;
    assign FULL     = w_full;
    assign OVFL     = r_ovfl;
    assign STATE    = r_state;
    assign EVT_CNT  = r_evt_cnt;
    assign LEVEL    = r_sync[SYNC_STAGES-1];

endmodule
